seq_ax_argmax: RTL



---
 rtl/seq_ax_pkg.sv | 16 +
 rtl/ax_mask_cmp.sv | 22 ++
 rtl/seq_ax_argmax.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_ax_pkg.sv
// Shared definitions for the sequential approximate-argmax stage and its planned tree variant.
package seq_ax_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t HOLD  = 2'd2;

    // Default approximate-compare mask for the Vertebral 3C classifier.
    localparam logic [14:0] CMP_MASK_VERTEBRAL = 15'h0070;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ax_mask_cmp.sv
// Masked "greater-than" used to decide whether a candidate score replaces the current best.
module ax_mask_cmp
    import seq_ax_pkg::*;
#(
    parameter int               VAL_W    = 15,
    parameter logic [VAL_W-1:0] CMP_MASK = VAL_W'(CMP_MASK_VERTEBRAL)
) (
    input  logic [VAL_W-1:0] best,
    input  logic [VAL_W-1:0] cand,
    input  logic             exact,
    output logic             take
);

    logic [VAL_W-1:0] eff_best;
    logic [VAL_W-1:0] eff_cand;

    assign eff_best = exact ? best : (best & CMP_MASK);
    assign eff_cand = exact ? cand : (cand & CMP_MASK);
    // Strictly greater keeps the earlier index on ties.
    assign take     = eff_cand > eff_best;

endmodule

// File: rtl/seq_ax_argmax.sv
// Streaming argmax over one frame of class scores, with optional masked (approximate) compare.
module seq_ax_argmax
    import seq_ax_pkg::*;
#(
    parameter int               VAL_W     = 15,
    parameter int               N_CLASSES = 3,
    parameter int               IDX_W     = idx_w(N_CLASSES),
    parameter logic [VAL_W-1:0] CMP_MASK  = VAL_W'(CMP_MASK_VERTEBRAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exact_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [VAL_W-1:0] out_val,
    output logic             out_err
);

    localparam int               CNT_W = $clog2(N_CLASSES + 1);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_CLASSES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [VAL_W-1:0] best_val;
    logic [IDX_W-1:0] best_idx;
    logic             exact_lat;
    logic             err;

    logic             accept;
    logic             in_range;
    logic             take;
    logic             upd;
    logic [VAL_W-1:0] nxt_val;
    logic [IDX_W-1:0] nxt_idx;

    ax_mask_cmp #(
        .VAL_W    (VAL_W),
        .CMP_MASK (CMP_MASK)
    ) u_cmp (
        .best  (best_val),
        .cand  (in_data),
        .exact (exact_lat),
        .take  (take)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Beats past the expected frame length are consumed but never compared.
    assign in_range  = cnt < N_CNT;
    assign upd       = in_range && take;
    assign nxt_val   = upd ? in_data : best_val;
    assign nxt_idx   = upd ? IDX_W'(cnt) : best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            exact_lat <= 1'b0;
            err       <= 1'b0;
            out_idx   <= '0;
            out_val   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        best_val  <= in_data;
                        best_idx  <= '0;
                        cnt       <= CNT_W'(1);
                        exact_lat <= exact_mode;
                        err       <= in_last;
                        if (in_last) begin
                            state   <= HOLD;
                            out_val <= in_data;
                            out_idx <= '0;
                            out_err <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        best_val <= nxt_val;
                        best_idx <= nxt_idx;
                        if (!in_range) err <= 1'b1;
                        if (cnt != N_CNT) cnt <= cnt + CNT_W'(1);
                        if (in_last) begin
                            state   <= HOLD;
                            out_val <= nxt_val;
                            out_idx <= nxt_idx;
                            out_err <= err || !in_range || (cnt != N_CNT - CNT_W'(1));
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
